mux_n_to_1_rr: RTL and testbench
================================

MUX_N_TO_1_RR -- requirements
Module: mux_n_to_1_rr

Interface
REQ-001 Parameter WIDTH SHALL default to 32: data width per channel in bits.
REQ-002 Parameter N SHALL default to 4: number of input channels, N >= 2.
REQ-003 Parameter SELW SHALL default to $clog2(N): width of channel index.
REQ-004 Clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Mode  input  1  0 = select mode (MODE_SEL), 1 = round-robin mode (MODE_RR).
REQ-007 Sel  input  SELW  channel index, used in MODE_SEL only.
REQ-008 InValid  input  N  per-channel data valid.
REQ-009 InData  input  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-010 InReady  output  N  per-channel accept, one-hot or zero.
REQ-011 OutValid  output  1  registered output holds a beat.
REQ-012 OutData  output  WIDTH  registered selected data.
REQ-013 OutChan  output  SELW  index of channel that supplied OutData.
REQ-014 OutReady  input  1  downstream accepts beat when OutValid & OutReady.

Function
REQ-015 Output register SHALL be loadable when OutValid==0 or (OutValid & OutReady) in the same cycle (full throughput, 1 beat/cycle).
REQ-016 Grant SHALL be combinational from Mode, Sel, InValid, arbitration pointer and load-enable; InReady = grant when loadable, else all zero.
REQ-017 MODE_SEL: grant channel Sel iff InValid[Sel]; Sel >= N SHALL grant nothing.
REQ-018 MODE_RR: grant first valid channel searching Ptr+1, Ptr+2, ... with wrap from N-1 to 0; Ptr = last granted channel.
REQ-019 Ptr SHALL update to granted index only on an actual transfer (InValid[i] & InReady[i]); unchanged otherwise and in MODE_SEL.
REQ-020 Transfer latency: input handshake at edge k -> OutValid, OutData, OutChan visible after edge k, i.e. 1 cycle.
REQ-021 While OutValid & !OutReady, OutData and OutChan SHALL hold stable and InReady SHALL be zero.
REQ-022 Accept with no new grant SHALL clear OutValid next cycle; accept with grant SHALL keep OutValid=1 with new data.
REQ-023 Mode or Sel change while a beat is held SHALL NOT alter the held beat; takes effect at next grant.
REQ-024 No valid inputs: no grant, Ptr unchanged, output register unchanged except per REQ-022.

Reset
REQ-025 On Reset=1 at a rising edge: OutValid=0, OutData=0, OutChan=0, Ptr=N-1 (first RR grant goes to channel 0).
REQ-026 Reset SHALL take priority over any transfer in the same cycle; a held beat is discarded; InReady SHALL be zero while Reset=1.

Structure
REQ-027 Shared package/include SHALL hold MODE_SEL/MODE_RR encodings and WIDTH/N defaults; no other constants.
REQ-028 Round-robin search SHALL be one sub-module rr_arbiter (inputs request vector, pointer; output one-hot grant, index, any-grant); datapath mux and output register stay in the top.

Verification
REQ-029 MODE_SEL, N=4, InData={40,30,20,10} (ch3..ch0), all valid, OutReady=1, Sel 0 then 1 -> OutData 10 then 20 one cycle after each, OutChan 0 then 1.
REQ-030 MODE_RR, all four valid, OutReady=1 for 6 cycles -> OutChan sequence 0,1,2,3,0,1; InReady one-hot each cycle.
REQ-031 MODE_RR, only ch2 valid after ch3 last granted -> search wraps 0,1,2, ch2 granted, OutChan=2, Ptr=2.
REQ-032 Backpressure: beat OutData=29 held, OutReady=0 for 3 cycles while Sel/Mode toggle -> OutData stays 29, InReady=0; OutReady=1 -> next beat loads same cycle.
REQ-033 Reset asserted while OutValid=1 with OutReady=0 -> next cycle OutValid=0, OutData=0, OutChan=0; first RR grant after release is ch0.
REQ-034 MODE_SEL, Sel=1 with InValid[1]=0, others valid -> no grant, InReady=0, OutValid deasserts after accept.

Source files
------------

// File: rtl/mux_n_to_1_rr_pkg.sv
// Shared encodings and default sizes for the N-to-1 select / round-robin mux.
package mux_n_to_1_rr_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N     = 4;

endpackage

// File: rtl/mux_n_to_1_rr_rr_arbiter.sv
// Round-robin search: first requester after ptr, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] idx,
  output logic            any
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    // ptr itself is visited last, so the previous winner has lowest priority
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        idx    = SELW'(c);
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_to_1_rr.sv
// N-to-1 mux with registered output, either fixed-select or round-robin grant,
// full-throughput valid/ready handshake on both sides.
module mux_n_to_1_rr
  import mux_n_to_1_rr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  input  logic               out_ready
);

  logic [SELW-1:0] ptr;
  logic [N-1:0]    rr_gnt;
  logic [SELW-1:0] rr_idx;
  logic            rr_any;
  logic            sel_ok;
  logic [N-1:0]    gnt;
  logic [SELW-1:0] gidx;
  logic            load;
  logic            xfer;

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .req (in_valid),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  always_comb begin
    sel_ok = (int'(sel) < N) && in_valid[sel];
    gnt    = '0;
    gidx   = '0;
    if (mode == MODE_RR) begin
      gnt  = rr_gnt;
      gidx = rr_idx;
    end else if (sel_ok) begin
      gnt[sel] = 1'b1;
      gidx     = sel;
    end
  end

  // Output register frees up in the same cycle its beat is taken downstream
  assign load     = !out_valid || out_ready;
  assign xfer     = load && !reset && ((mode == MODE_RR) ? rr_any : sel_ok);
  assign in_ready = (load && !reset) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SELW'(N - 1);
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[gidx*WIDTH +: WIDTH];
        out_chan <= gidx;
        if (mode == MODE_RR) ptr <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// Bench for mux_n_to_1_rr: reference model of the mux plus directed literal checks.
module tb_mux_n_to_1_rr;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;
  logic               out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_to_1_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  // Model state: what the output register holds and who was served last
  bit       m_valid = 1'b0;
  int       m_data  = 0;
  int       m_chan  = 0;
  int       m_ptr   = N - 1;

  function automatic int exp_grant();
    if (reset) return -1;
    if (m_valid && !out_ready) return -1;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (reset) begin
      m_valid = 1'b0;
      m_data  = 0;
      m_chan  = 0;
      m_ptr   = N - 1;
    end else begin
      g = exp_grant();
      if (!m_valid || out_ready) begin
        m_valid = (g >= 0);
        if (g >= 0) begin
          m_data = int'(in_data[g*WIDTH +: WIDTH]);
          m_chan = g;
          if (mode == 1'b1) m_ptr = g;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mid-cycle compare of every DUT output against the model, then advance one edge
  task automatic tick();
    int g;
    @(negedge clk);
    g = exp_grant();
    check("model in_ready", int'(in_ready), (g >= 0) ? (1 << g) : 0);
    check("model out_valid", int'(out_valid), int'(m_valid));
    check("model out_data", int'(out_data), m_data);
    check("model out_chan", int'(out_chan), m_chan);
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int v, input int d, input int c);
    check({name, " valid"}, int'(out_valid), v);
    check({name, " data"}, int'(out_data), d);
    check({name, " chan"}, int'(out_chan), c);
  endtask

  task automatic lit_rdy(input string name, input int r);
    #1;
    check({name, " in_ready"}, int'(in_ready), r);
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    in_data = {32'd40, 32'd30, 32'd20, 32'd10};
    @(posedge clk); #1;
    tick();
    lit("reset", 0, 0, 0);

    // Fixed select: ch0 then ch1
    reset = 1'b0; in_valid = 4'hF; out_ready = 1'b1; sel = 2'd0;
    lit_rdy("sel0", 4'b0001);
    tick(); lit("sel0", 1, 10, 0);
    sel = 2'd1;
    tick(); lit("sel1", 1, 20, 1);

    // Round robin from reset pointer: 0,1,2,3,0,1 then 2,3
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lit_rdy("rr onehot", 1 << (i % 4));
      tick();
      lit("rr seq", 1, 10 * ((i % 4) + 1), i % 4);
    end

    // Only ch2 valid after ch3 served: search wraps to ch2
    in_valid = 4'b0100;
    tick(); lit("rr wrap", 1, 30, 2);
    // Accept with nothing to grant drops valid, register keeps last beat
    in_valid = 4'b0000;
    tick(); lit("idle", 0, 30, 2);

    // Backpressure holds 29 while mode/sel wiggle
    in_data = {32'd40, 32'd30, 32'd20, 32'd29};
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
    tick(); lit("load29", 1, 29, 0);
    out_ready = 1'b0; in_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      mode = ~mode; sel = SELW'(i + 1);
      lit_rdy("stall", 0);
      tick(); lit("stall", 1, 29, 0);
    end
    out_ready = 1'b1; mode = 1'b0; sel = 2'd2;
    lit_rdy("release", 4'b0100);
    tick(); lit("release", 1, 30, 2);

    // Reset while a beat is stalled, then first RR grant is ch0
    out_ready = 1'b0; reset = 1'b1;
    tick(); lit("rst held", 0, 0, 0);
    out_ready = 1'b1;
    lit_rdy("rst", 0);
    tick();
    reset = 1'b0; mode = 1'b1;
    tick(); lit("rst rr", 1, 29, 0);

    // Selected channel not valid: no grant, output drains
    mode = 1'b0; sel = 2'd1; in_valid = 4'b1101;
    lit_rdy("sel invalid", 0);
    tick(); lit("sel invalid", 0, 29, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
